wb_sram: RTL and testbench

- Parametrised Wishbone B3 classic slave wrapping an inferred single-port synchronous RAM.
- Adds byte-lane writes (SEL), configurable depth and width, and configurable read wait states.
- Decodes a base address and signals ERR for out-of-window accesses.
- Sits between the SoC RAM bus and on-chip block RAM; next-generation replacement for the fixed one-cycle RAM slave.

---
 rtl/wb_defs.sv | 21 ++
 rtl/wb_sram_bank.sv | 32 +++
 rtl/wb_sram.sv | 118 +++++++++++
 tb/tb_wb_sram.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_defs.sv
// rtl/wb_defs.sv - shared Wishbone SRAM slave definitions
package wb_defs;

  localparam int WB_ADDR_WIDTH = 32;
  localparam int LANE_WIDTH    = 8;
  localparam int MAX_READ_WAIT = 3;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_WAIT = 2'd1,
    RESP    = 2'd2
  } wb_state_t;

  // Wait counter load value, clamped to what the 2-bit counter can hold.
  function automatic logic [1:0] wait_load(input int n);
    int c;
    c = (n > MAX_READ_WAIT) ? MAX_READ_WAIT : ((n < 0) ? 0 : n);
    return c[1:0];
  endfunction

endpackage

// File: rtl/wb_sram_bank.sv
// rtl/wb_sram_bank.sv - inferred byte-enable single-port RAM with registered output
module wb_sram_bank
  import wb_defs::*;
#(
  parameter int    ADDR_WIDTH = 12,
  parameter int    DATA_WIDTH = 32,
  parameter int    SEL_WIDTH  = DATA_WIDTH / LANE_WIDTH,
  parameter string INIT_FILE  = ""
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [SEL_WIDTH-1:0]  be,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] din,
  output logic [DATA_WIDTH-1:0] dout
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // Per-lane write (read-first) and registered read of the addressed word.
  always_ff @(posedge clk) begin
    for (int i = 0; i < SEL_WIDTH; i++) begin
      if (we && be[i]) begin
        mem[addr][i*LANE_WIDTH +: LANE_WIDTH] <= din[i*LANE_WIDTH +: LANE_WIDTH];
      end
    end
    dout <= mem[addr];
  end

endmodule

// File: rtl/wb_sram.sv
// rtl/wb_sram.sv - Wishbone classic slave around a byte-lane block RAM
module wb_sram
  import wb_defs::*;
#(
  parameter int          ADDR_WIDTH = 12,
  parameter int          DATA_WIDTH = 32,
  parameter int          READ_WAIT  = 0,
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
  parameter string       INIT_FILE  = ""
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [31:0]               addr,
  input  logic [DATA_WIDTH-1:0]     wdata,
  input  logic [DATA_WIDTH/8-1:0]   sel,
  input  logic                      we,
  input  logic                      cyc,
  input  logic                      stb,
  output logic [DATA_WIDTH-1:0]     rdata,
  output logic                      ack,
  output logic                      err
);

  localparam int SEL_WIDTH = DATA_WIDTH / LANE_WIDTH;

  wb_state_t             state;
  logic [1:0]            wait_cnt;
  logic [ADDR_WIDTH-1:0] held_idx;

  logic [ADDR_WIDTH-1:0] word_idx;
  logic                  in_win;
  logic                  req;
  logic                  bank_we;
  logic [ADDR_WIDTH-1:0] bank_addr;
  logic                  unused_addr_bits;

  // Byte offset is irrelevant: the master selects lanes with sel.
  assign unused_addr_bits = ^addr[1:0];

  assign word_idx = addr[ADDR_WIDTH+1:2];
  assign in_win   = (addr[WB_ADDR_WIDTH-1:ADDR_WIDTH+2] == BASE_ADDR[WB_ADDR_WIDTH-1:ADDR_WIDTH+2]);
  assign req      = cyc && stb;

  // Writes commit at acceptance; a write on the reset edge is suppressed.
  assign bank_we = (state == IDLE) && req && in_win && we && !reset;

  // Once accepted the RAM keeps reading the latched word, so rdata stays
  // stable through the ack cycle even if the master moves addr.
  assign bank_addr = (state == IDLE) ? word_idx : held_idx;

  wb_sram_bank #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH),
    .SEL_WIDTH  (SEL_WIDTH),
    .INIT_FILE  (INIT_FILE)
  ) u_bank (
    .clk  (clk),
    .we   (bank_we),
    .be   (sel),
    .addr (bank_addr),
    .din  (wdata),
    .dout (rdata)
  );

  // Transfer FSM: accept, optional read wait, one-cycle ack/err response.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      ack      <= 1'b0;
      err      <= 1'b0;
      wait_cnt <= 2'd0;
      held_idx <= '0;
    end else begin
      case (state)
        IDLE: begin
          ack <= 1'b0;
          err <= 1'b0;
          if (req) begin
            held_idx <= word_idx;
            if (!in_win) begin
              state <= RESP;
              err   <= 1'b1;
            end else if (we || (READ_WAIT == 0)) begin
              state <= RESP;
              ack   <= 1'b1;
            end else begin
              state    <= RD_WAIT;
              wait_cnt <= wait_load(READ_WAIT);
            end
          end
        end
        RD_WAIT: begin
          if (!cyc) begin
            state    <= IDLE;
            wait_cnt <= 2'd0;
          end else if (wait_cnt <= 2'd1) begin
            state    <= RESP;
            ack      <= 1'b1;
            wait_cnt <= 2'd0;
          end else begin
            wait_cnt <= wait_cnt - 2'd1;
          end
        end
        RESP: begin
          ack   <= 1'b0;
          err   <= 1'b0;
          state <= IDLE;
        end
        default: begin
          ack   <= 1'b0;
          err   <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wb_sram.sv
// tb/tb_wb_sram.sv - scoreboard bench for wb_sram against a word-array model
module tb_wb_sram;

  localparam int          AW   = 6;
  localparam int          RW   = 2;
  localparam logic [31:0] BASE = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic [3:0]  sel = '0;
  logic        we = 1'b0;
  logic        cyc = 1'b0;
  logic        stb = 1'b0;
  logic [31:0] rdata;
  logic        ack;
  logic        err;

  wb_sram #(
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (32),
    .READ_WAIT  (RW),
    .BASE_ADDR  (BASE),
    .INIT_FILE  ("")
  ) dut (
    .clk   (clk),
    .reset (reset),
    .addr  (addr),
    .wdata (wdata),
    .sel   (sel),
    .we    (we),
    .cyc   (cyc),
    .stb   (stb),
    .rdata (rdata),
    .ack   (ack),
    .err   (err)
  );

  always #5 clk = ~clk;

  int cyc_n = 0;
  always @(posedge clk) cyc_n <= cyc_n + 1;

  typedef struct {
    bit          is_err;
    bit          chk_data;
    logic [31:0] data;
    int          cyc;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] mem_m [2**AW];
  int          vectors = 0;
  int          misc = 0;

  function automatic bit win(input logic [31:0] a);
    return a[31:AW+2] == BASE[31:AW+2];
  endfunction

  function automatic int widx(input logic [31:0] a);
    return int'(a[AW+1:2]);
  endfunction

  // Monitor: every ack/err must match the head of the expected queue.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (!reset && (ack || err)) begin
      vectors++;
      if (ack && err) begin
        misc++;
        $display("FAIL ack_err_exclusive ack=%b err=%b required not both", ack, err);
      end
      if (exp_q.size() == 0) begin
        vectors++; misc++;
        $display("FAIL unexpected_resp cycle=%0d ack=%b err=%b required none", cyc_n, ack, err);
      end else begin
        e = exp_q.pop_front();
        vectors++;
        if (err !== e.is_err || ack !== !e.is_err) begin
          misc++;
          $display("FAIL resp_kind ack=%b err=%b required err=%b", ack, err, e.is_err);
        end
        vectors++;
        if (cyc_n != e.cyc) begin
          misc++;
          $display("FAIL resp_cycle got=%0d required=%0d", cyc_n, e.cyc);
        end
        if (e.chk_data) begin
          vectors++;
          if (rdata !== e.data) begin
            misc++;
            $display("FAIL rdata got=%h required=%h", rdata, e.data);
          end
        end
      end
    end
  end

  function automatic exp_t predict(input logic [31:0] a, input bit w, input logic [31:0] d,
                                   input logic [3:0] s, input int c);
    exp_t e;
    e.is_err = !win(a);
    e.chk_data = 1'b0;
    e.data = '0;
    if (e.is_err) begin
      e.cyc = c + 1;
    end else if (w) begin
      for (int i = 0; i < 4; i++)
        if (s[i]) mem_m[widx(a)][8*i +: 8] = d[8*i +: 8];
      e.cyc = c + 1;
    end else begin
      e.chk_data = 1'b1;
      e.data = mem_m[widx(a)];
      e.cyc = c + 1 + RW;
    end
    return e;
  endfunction

  task automatic xfer(input logic [31:0] a, input bit w, input logic [31:0] d,
                      input logic [3:0] s, input bit drop_stb);
    bit got;
    @(posedge clk); #1;
    exp_q.push_back(predict(a, w, d, s, cyc_n));
    addr = a; we = w; wdata = d; sel = s; cyc = 1'b1; stb = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (ack || err) got = 1'b1;
      else if (drop_stb && i >= 1) stb = 1'b0;
    end
    if (!got) begin
      vectors++; misc++;
      $display("FAIL xfer_timeout addr=%h got=no_resp required=resp", a);
    end
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
  endtask

  task automatic b2b_reads(input logic [31:0] a);
    exp_t e;
    int got;
    @(posedge clk); #1;
    e = predict(a, 1'b0, '0, 4'hF, cyc_n);
    exp_q.push_back(e);
    e.cyc = e.cyc + 4;
    exp_q.push_back(e);
    addr = a; we = 1'b0; sel = 4'hF; cyc = 1'b1; stb = 1'b1;
    got = 0;
    for (int i = 0; i < 40 && got < 2; i++) begin
      @(negedge clk);
      if (ack || err) got++;
    end
    if (got < 2) begin
      vectors++; misc++;
      $display("FAIL b2b_timeout got=%0d required=2", got);
    end
    cyc = 1'b0; stb = 1'b0;
  endtask

  task automatic abort_read(input logic [31:0] a);
    bit bad;
    @(posedge clk); #1;
    addr = a; we = 1'b0; sel = 4'hF; cyc = 1'b1; stb = 1'b1;
    @(posedge clk); #1;
    cyc = 1'b0; stb = 1'b0;
    bad = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (ack || err) bad = 1'b1;
    end
    vectors++;
    if (bad) begin
      misc++;
      $display("FAIL abort_no_resp got=resp required=none");
    end
  endtask

  task automatic reset_mid_read(input logic [31:0] a);
    @(posedge clk); #1;
    addr = a; we = 1'b0; sel = 4'hF; cyc = 1'b1; stb = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    vectors++;
    if (ack !== 1'b0 || err !== 1'b0) begin
      misc++;
      $display("FAIL reset_mid_read ack=%b err=%b required 0 0", ack, err);
    end
    reset = 1'b0; cyc = 1'b0; stb = 1'b0;
  endtask

  task automatic write_under_reset(input logic [31:0] a, input logic [31:0] d);
    @(posedge clk); #1;
    reset = 1'b1;
    addr = a; we = 1'b1; wdata = d; sel = 4'hF; cyc = 1'b1; stb = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0; cyc = 1'b0; stb = 1'b0; we = 1'b0;
  endtask

  initial begin
    logic [31:0] ra;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    vectors++;
    if (ack !== 1'b0 || err !== 1'b0) begin
      misc++;
      $display("FAIL reset_state ack=%b err=%b required 0 0", ack, err);
    end

    for (int i = 0; i < 2**AW; i++)
      xfer(BASE | (i << 2), 1'b1, $urandom, 4'hF, 1'b0);

    xfer(BASE | 32'h10, 1'b1, 32'hDEAD_BEEF, 4'hF, 1'b0);
    xfer(BASE | 32'h10, 1'b0, '0, 4'hF, 1'b0);
    xfer(BASE | 32'h10, 1'b1, 32'h0000_0055, 4'b0001, 1'b0);
    xfer(BASE | 32'h10, 1'b1, 32'hAA00_0000, 4'b1000, 1'b0);
    xfer(BASE | 32'h13, 1'b0, '0, 4'b0010, 1'b0);
    xfer(BASE | 32'h10, 1'b1, 32'hFFFF_FFFF, 4'b0000, 1'b0);
    xfer(BASE | 32'h10, 1'b0, '0, 4'hF, 1'b0);

    xfer(32'h0000_0010, 1'b1, 32'h1111_1111, 4'hF, 1'b0);
    xfer(BASE | 32'h110, 1'b0, '0, 4'hF, 1'b0);
    xfer(BASE | 32'h10, 1'b0, '0, 4'hF, 1'b0);

    xfer(BASE | 32'h10, 1'b0, '0, 4'hF, 1'b1);
    b2b_reads(BASE | 32'h10);

    abort_read(BASE | 32'h20);
    xfer(BASE | 32'h20, 1'b0, '0, 4'hF, 1'b0);

    reset_mid_read(BASE | 32'h10);
    write_under_reset(BASE | 32'h10, 32'h1234_5678);
    xfer(BASE | 32'h10, 1'b0, '0, 4'hF, 1'b0);

    for (int i = 0; i < 80; i++) begin
      ra = {BASE[31:AW+2], 6'($urandom_range(0, 2**AW - 1)), 2'($urandom_range(0, 3))};
      if ($urandom_range(0, 7) == 0) ra[31] = 1'b0;
      xfer(ra, 1'($urandom_range(0, 1)), $urandom, 4'($urandom_range(0, 15)),
           1'($urandom_range(0, 3) == 0));
    end

    repeat (5) @(posedge clk);
    #1;
    vectors++;
    if (exp_q.size() != 0) begin
      misc++;
      $display("FAIL drain outstanding=%0d required=0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, misc);
    $finish;
  end

endmodule
